mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
// - Shares the single CPU memory port (addr/we/wdata -> rdata) between three requesters:
//   the instruction fetcher (F), the executor load/store/stack unit (E) and the OAM DMA engine (D).
// - Arbitrates one beat per cycle, with two lock modes: executor read-modify-write and DMA burst.
// - Registers the winning beat onto the memory bus and routes the returned read data back to its owner.
// - Sits between the fetch/execute pipeline and the memory map decoder.
// PARAMETERS
// - ADDR_WIDTH     16   address width.
// - REG_WIDTH      8    data width.
// - DMA_MAX_BURST  256  beats after which a DMA lock is forcibly released.
// - STARVE_MAX     4    consecutive denied fetch cycles before the fetcher is promoted (guard build only).
// PORTS
// - phi1                 in   1           system clock; all state updates on posedge.
// - reset                in   1           asynchronous, active-high reset.
// - req_f, addr_f        in   1, ADDR     fetcher read request and address.
// - req_e, addr_e        in   1, ADDR     executor request and address.
// - we_e, wdata_e        in   1, REG      executor write enable and write data.
// - lock_e               in   1           executor RMW lock; sampled only with a granted E beat.
// - req_d, addr_d        in   1, ADDR     DMA request and address.
// - we_d, wdata_d        in   1, REG      DMA write enable and write data.
// - last_d               in   1           final beat of a DMA burst.
// - mem_rdata            in   REG         memory read data, valid 1 cycle after mem_addr.
// - gnt_f, gnt_e, gnt_d  out  1 each      combinational grant; one-hot or zero.
// - mem_addr             out  ADDR        registered bus address.
// - mem_we               out  1           registered write strobe.
// - mem_wdata            out  REG         registered write data.
// - rvalid_f, rvalid_e, rvalid_d  out  1 each  read data valid for that owner.
// - rdata                out  REG         mem_rdata passthrough.
// - dma_active           out  1           high while in LOCK_D.
// BEHAVIOUR
// - Reset state:
//   - state=ARB, starve_cnt=0, burst_cnt=0, owner pipeline=none.
//   - mem_addr=0, mem_we=0, mem_wdata=0.
//   - all gnt_*=0, all rvalid_*=0, dma_active=0.
// - Handshake:
//   - A requester holds req/addr/we/wdata stable until it sees gnt high.
//   - gnt high in cycle N means the beat is accepted at the end of N.
//   - The requester may present its next beat in N+1.
// - Pipeline:
//   - Beat accepted at N: mem_* driven during N+1.
//   - For a read, rvalid_<owner>=1 in N+2 with rdata=mem_rdata.
//   - Writes produce no rvalid.
//   - With no grant in a cycle, mem_we=0 next cycle and mem_addr/mem_wdata hold.
// - State ARB (fixed priority D > E > F):
//   - D granted: if last_d=0, go to LOCK_D with burst_cnt=1.
//   - E granted with lock_e=1: go to LOCK_E.
// - State LOCK_E:
//   - Only E may be granted; F and D wait.
//   - Return to ARB at the end of a granted E beat with lock_e=0.
//   - An idle cycle (req_e=0) keeps the lock.
// - State LOCK_D:
//   - Only D may be granted; dma_active=1.
//   - burst_cnt increments per granted D beat.
//   - Return to ARB after a granted beat with last_d=1, or when burst_cnt reaches DMA_MAX_BURST.
//   - req_d low mid-burst: lock held, no beat, mem_we=0.
// - Simultaneous events:
//   - last_d and lock_e are ignored unless the corresponding beat is granted.
//   - A beat granted in the final lock cycle is delivered normally.
// - Reset mid-operation:
//   - Immediately forces the reset state, including from LOCK_D/LOCK_E.
//   - In-flight rvalids are squashed.
// - Counters:
//   - burst_cnt saturates; it never wraps.
//   - Address and data pass through unmodified, with no width arithmetic.
// CONFIGURATION
// - ARB_STARVE_GUARD_EN defined:
//   - In ARB, starve_cnt increments each cycle req_f=1 and gnt_f=0; it clears on gnt_f and when req_f=0.
//   - When starve_cnt==STARVE_MAX, F beats E for one grant, then the counter clears.
//   - D is never preempted; LOCK_E/LOCK_D do not count.
// - ARB_STARVE_GUARD_EN undefined:
//   - Pure fixed priority; starve_cnt is absent and F can starve indefinitely.
// TESTING
// - Reset released, req_f=1 addr_f=16'h8000, mem_rdata=8'hA9:
//   - gnt_f=1 cycle 0; mem_addr=16'h8000 cycle 1; rvalid_f=1, rdata=8'hA9 cycle 2.
// - req_f, req_e (we_e=1 addr_e=16'h0200 wdata_e=8'h55) and req_d all high in the same cycle:
//   - gnt_d only.
//   - With last_d=1, next cycle gnt_e; then mem_we=1, mem_addr=16'h0200, mem_wdata=8'h55.
//   - gnt_f follows.
// - DMA burst of 4 with last_d on beat 4, req_e held high throughout:
//   - dma_active=1 for 4 beats, gnt_e=0 throughout.
//   - gnt_e=1 the cycle after beat 4.
// - DMA with last_d never set:
//   - Lock released after exactly DMA_MAX_BURST=256 granted beats; a pending req_e is granted next.
// - lock_e=1 on read beat 16'h0010, req_d raised mid-RMW:
//   - gnt_d=0 until the E write beat with lock_e=0 is granted; gnt_d=1 the following cycle.
// - Guard build, req_e and req_f held high, STARVE_MAX=4:
//   - gnt_e for 4 cycles, gnt_f on the 5th, then E again.
//   - Non-guard build: gnt_f never asserts.
// - Assert reset while in LOCK_D with a read in flight:
//   - All gnt/rvalid/dma_active=0 immediately; after release, ARB accepts req_f.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the three memory requesters, the arbiter and the memory port.
// The arbiter binds to the slave modport; the requester/memory side uses master.
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int REG_WIDTH  = 8
);
    logic                  req_f;
    logic [ADDR_WIDTH-1:0] addr_f;
    logic                  req_e;
    logic [ADDR_WIDTH-1:0] addr_e;
    logic                  we_e;
    logic [REG_WIDTH-1:0]  wdata_e;
    logic                  lock_e;
    logic                  req_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  we_d;
    logic [REG_WIDTH-1:0]  wdata_d;
    logic                  last_d;
    logic [REG_WIDTH-1:0]  mem_rdata;
    logic                  gnt_f;
    logic                  gnt_e;
    logic                  gnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [REG_WIDTH-1:0]  mem_wdata;
    logic                  rvalid_f;
    logic                  rvalid_e;
    logic                  rvalid_d;
    logic [REG_WIDTH-1:0]  rdata;
    logic                  dma_active;

    modport master (
        output req_f, addr_f, req_e, addr_e, we_e, wdata_e, lock_e,
               req_d, addr_d, we_d, wdata_d, last_d, mem_rdata,
        input  gnt_f, gnt_e, gnt_d, mem_addr, mem_we, mem_wdata,
               rvalid_f, rvalid_e, rvalid_d, rdata, dma_active
    );

    modport slave (
        input  req_f, addr_f, req_e, addr_e, we_e, wdata_e, lock_e,
               req_d, addr_d, we_d, wdata_d, last_d, mem_rdata,
        output gnt_f, gnt_e, gnt_d, mem_addr, mem_we, mem_wdata,
               rvalid_f, rvalid_e, rvalid_d, rdata, dma_active
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the CPU memory port between fetcher (F), executor (E) and OAM DMA (D).
// Optional fetch anti-starvation guard: define ARB_STARVE_GUARD_EN.
//
// state     | meaning
// ST_ARB    | fixed priority D > E > F, one beat per cycle
// ST_LOCK_E | executor read-modify-write in progress, only E may be granted
// ST_LOCK_D | DMA burst in progress, only D may be granted
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH    = 16,
    parameter int REG_WIDTH     = 8,
    parameter int DMA_MAX_BURST = 256,
    parameter int STARVE_MAX    = 4
) (
    input  logic              i_phi1,
    input  logic              i_reset,
    mem_bus_arbiter_if.slave  bus
);
    localparam int BW = $clog2(DMA_MAX_BURST + 1);

    typedef enum logic [1:0] {ST_ARB, ST_LOCK_E, ST_LOCK_D} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [BW-1:0]         r_burst_cnt;
    logic [BW-1:0]         w_burst_next;
    logic                  w_gnt_f;
    logic                  w_gnt_e;
    logic                  w_gnt_d;
    logic                  w_promote_f;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_we;
    logic [REG_WIDTH-1:0]  r_mem_wdata;
    logic [2:0]            r_rd_s1;
    logic [2:0]            r_rvalid;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] r_starve_cnt;
    logic [SW-1:0] w_starve_next;

    assign w_promote_f = bus.req_f && (r_starve_cnt == SW'(STARVE_MAX));

    // Counts only while arbitrating; saturates so a D grant at the limit keeps F promoted.
    always_comb begin
        w_starve_next = r_starve_cnt;
        if (r_state == ST_ARB) begin
            if (!bus.req_f || w_gnt_f)
                w_starve_next = '0;
            else if (r_starve_cnt != SW'(STARVE_MAX))
                w_starve_next = r_starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge i_phi1 or posedge i_reset) begin
        if (i_reset) r_starve_cnt <= '0;
        else         r_starve_cnt <= w_starve_next;
    end
`else
    assign w_promote_f = 1'b0;
`endif

    always_ff @(posedge i_phi1 or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_ARB;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_next;
            r_burst_cnt <= w_burst_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_burst_next = r_burst_cnt;
        w_gnt_f      = 1'b0;
        w_gnt_e      = 1'b0;
        w_gnt_d      = 1'b0;
        if (!i_reset) begin
            case (r_state)
                ST_ARB: begin
                    if (bus.req_d) begin
                        w_gnt_d = 1'b1;
                        if (!bus.last_d) begin
                            w_next       = ST_LOCK_D;
                            w_burst_next = BW'(1);
                        end
                    end else if (bus.req_e && !w_promote_f) begin
                        w_gnt_e = 1'b1;
                        if (bus.lock_e) w_next = ST_LOCK_E;
                    end else if (bus.req_f) begin
                        w_gnt_f = 1'b1;
                    end
                end
                ST_LOCK_E: begin
                    if (bus.req_e) begin
                        w_gnt_e = 1'b1;
                        if (!bus.lock_e) w_next = ST_ARB;
                    end
                end
                ST_LOCK_D: begin
                    if (bus.req_d) begin
                        w_gnt_d = 1'b1;
                        if (r_burst_cnt != BW'(DMA_MAX_BURST))
                            w_burst_next = r_burst_cnt + BW'(1);
                        if (bus.last_d || w_burst_next == BW'(DMA_MAX_BURST))
                            w_next = ST_ARB;
                    end
                end
                default: w_next = ST_ARB;
            endcase
        end
    end

    // Read owner travels two stages so rvalid lines up with mem_rdata.
    always_ff @(posedge i_phi1 or posedge i_reset) begin
        if (i_reset) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_rd_s1     <= '0;
            r_rvalid    <= '0;
        end else begin
            r_mem_we <= 1'b0;
            r_rd_s1  <= '0;
            r_rvalid <= r_rd_s1;
            if (w_gnt_d) begin
                r_mem_addr  <= bus.addr_d;
                r_mem_we    <= bus.we_d;
                r_mem_wdata <= bus.wdata_d;
                r_rd_s1     <= {!bus.we_d, 2'b00};
            end else if (w_gnt_e) begin
                r_mem_addr  <= bus.addr_e;
                r_mem_we    <= bus.we_e;
                r_mem_wdata <= bus.wdata_e;
                r_rd_s1     <= {1'b0, !bus.we_e, 1'b0};
            end else if (w_gnt_f) begin
                r_mem_addr  <= bus.addr_f;
                r_mem_wdata <= '0;
                r_rd_s1     <= 3'b001;
            end
        end
    end

    assign bus.gnt_f      = w_gnt_f;
    assign bus.gnt_e      = w_gnt_e;
    assign bus.gnt_d      = w_gnt_d;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.rvalid_f   = r_rvalid[0];
    assign bus.rvalid_e   = r_rvalid[1];
    assign bus.rvalid_d   = r_rvalid[2];
    assign bus.rdata      = bus.mem_rdata;
    assign bus.dma_active = (r_state == ST_LOCK_D);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, directed corner sequences,
// and constrained-random traffic against a transaction-level reference model.
module tb_mem_bus_arbiter;
    localparam int MAXB = 256;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_WIDTH(16), .REG_WIDTH(8)) bus();

    mem_bus_arbiter #(.ADDR_WIDTH(16), .REG_WIDTH(8), .DMA_MAX_BURST(MAXB), .STARVE_MAX(SMAX))
        dut (.i_phi1(clk), .i_reset(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 = arbitrating, 1 = executor locked, 2 = DMA locked.
    int          m_mode, m_burst, m_starve, m_s1, m_rv;
    logic [15:0] m_addr;
    logic        m_we;
    logic [7:0]  m_wdata;
    logic [2:0]  m_g;
    logic [2:0]  last_gnt;

    typedef struct {
        logic       rf;
        logic       re;
        logic       rd;
        logic [2:0] eg;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_burst = 0; m_starve = 0; m_s1 = -1; m_rv = -1;
        m_addr = '0; m_we = 1'b0; m_wdata = '0;
    endtask

    function automatic logic [2:0] model_gnt();
        logic promote;
        if (rst) return 3'b000;
        if (m_mode == 1) return {1'b0, bus.req_e, 1'b0};
        if (m_mode == 2) return {bus.req_d, 2'b00};
        if (bus.req_d) return 3'b100;
`ifdef ARB_STARVE_GUARD_EN
        promote = bus.req_f && (m_starve >= SMAX);
`else
        promote = 1'b0;
`endif
        if (bus.req_e && !promote) return 3'b010;
        if (bus.req_f) return 3'b001;
        return 3'b000;
    endfunction

    task automatic model_step(input logic [2:0] g);
        int prev_mode;
        prev_mode = m_mode;
        m_rv = m_s1;
        m_s1 = -1;
        m_we = 1'b0;
        if (g[2]) begin
            m_addr = bus.addr_d; m_we = bus.we_d;
            if (bus.we_d) m_wdata = bus.wdata_d; else m_s1 = 2;
        end else if (g[1]) begin
            m_addr = bus.addr_e; m_we = bus.we_e;
            if (bus.we_e) m_wdata = bus.wdata_e; else m_s1 = 1;
        end else if (g[0]) begin
            m_addr = bus.addr_f; m_s1 = 0;
        end
        case (prev_mode)
            0: begin
                if (g[2] && !bus.last_d) begin m_mode = 2; m_burst = 1; end
                else if (g[1] && bus.lock_e) m_mode = 1;
                if (bus.req_f && !g[0]) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
                else m_starve = 0;
            end
            1: if (g[1] && !bus.lock_e) m_mode = 0;
            default: if (g[2]) begin
                m_burst = (m_burst < MAXB) ? m_burst + 1 : MAXB;
                if (bus.last_d || m_burst == MAXB) m_mode = 0;
            end
        endcase
    endtask

    // Caller drives inputs at posedge+1; returns at the next posedge+1.
    task automatic cycle();
        #1;
        m_g = model_gnt();
        last_gnt = {bus.gnt_d, bus.gnt_e, bus.gnt_f};
        chk("gnt", last_gnt, m_g);
        model_step(m_g);
        @(posedge clk); #1;
        chk("mem_we", bus.mem_we, m_we);
        chk("mem_addr", bus.mem_addr, m_addr);
        if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
        chk("rvalid", {bus.rvalid_d, bus.rvalid_e, bus.rvalid_f}, (m_rv < 0) ? 0 : (1 << m_rv));
        chk("dma_active", bus.dma_active, m_mode == 2);
        if (m_rv >= 0) chk("rdata", bus.rdata, bus.mem_rdata);
    endtask

    task automatic clear_inputs();
        bus.req_f = 0; bus.addr_f = '0;
        bus.req_e = 0; bus.addr_e = '0; bus.we_e = 0; bus.wdata_e = '0; bus.lock_e = 0;
        bus.req_d = 0; bus.addr_d = '0; bus.we_d = 0; bus.wdata_d = '0; bus.last_d = 0;
        bus.mem_rdata = '0;
    endtask

    task automatic flush(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " gnt"}, {bus.gnt_d, bus.gnt_e, bus.gnt_f}, 0);
        chk({name, " rvalid"}, {bus.rvalid_d, bus.rvalid_e, bus.rvalid_f}, 0);
        chk({name, " dma_active"}, bus.dma_active, 0);
        chk({name, " mem"}, {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    endtask

    initial begin
        logic [9:0] pat;
        logic [9:0] pat_exp;
        int         cnt;
        bit         pf, pe, pd;

        vt[0] = '{1'b0, 1'b0, 1'b0, 3'b000};
        vt[1] = '{1'b1, 1'b0, 1'b0, 3'b001};
        vt[2] = '{1'b0, 1'b1, 1'b0, 3'b010};
        vt[3] = '{1'b1, 1'b1, 1'b0, 3'b010};
        vt[4] = '{1'b0, 1'b0, 1'b1, 3'b100};
        vt[5] = '{1'b1, 1'b1, 1'b1, 3'b100};
        vt[6] = '{1'b1, 1'b0, 1'b1, 3'b100};
        vt[7] = '{1'b0, 1'b1, 1'b1, 3'b100};
        vt[8] = '{1'b1, 1'b0, 1'b0, 3'b001};

        // Reset: outputs idle even with requests pending.
        clear_inputs();
        model_reset();
        bus.req_f = 1; bus.req_d = 1;
        #2;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 0;
        clear_inputs();

        // First fetch after reset.
        bus.req_f = 1; bus.addr_f = 16'h8000; bus.mem_rdata = 8'hA9;
        cycle();
        chk("A gnt_f", last_gnt, 3'b001);
        chk("A mem_addr", bus.mem_addr, 16'h8000);
        bus.req_f = 0;
        cycle();
        chk("A rvalid_f", bus.rvalid_f, 1);
        chk("A rdata", bus.rdata, 8'hA9);
        flush(2);

        // Fixed-priority vector table.
        for (int i = 0; i < 9; i++) begin
            bus.req_f = vt[i].rf; bus.addr_f = 16'($urandom);
            bus.req_e = vt[i].re; bus.addr_e = 16'($urandom);
            bus.we_e = 1'($urandom_range(0, 1)); bus.wdata_e = 8'($urandom); bus.lock_e = 0;
            bus.req_d = vt[i].rd; bus.addr_d = 16'($urandom);
            bus.we_d = 1'($urandom_range(0, 1)); bus.wdata_d = 8'($urandom); bus.last_d = 1;
            bus.mem_rdata = 8'($urandom);
            cycle();
            chk($sformatf("vec%0d", i), last_gnt, vt[i].eg);
        end
        flush(3);

        // All three request together, single-beat DMA.
        bus.req_f = 1; bus.addr_f = 16'h4000;
        bus.req_e = 1; bus.we_e = 1; bus.addr_e = 16'h0200; bus.wdata_e = 8'h55;
        bus.req_d = 1; bus.addr_d = 16'h1234; bus.last_d = 1;
        cycle();
        chk("B gnt_d", last_gnt, 3'b100);
        bus.req_d = 0;
        cycle();
        chk("B gnt_e", last_gnt, 3'b010);
        chk("B write", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 16'h0200, 8'h55});
        bus.req_e = 0;
        cycle();
        chk("B gnt_f", last_gnt, 3'b001);
        flush(3);

        // Four-beat DMA burst with E waiting.
        bus.req_e = 1; bus.addr_e = 16'h0300;
        for (int i = 0; i < 4; i++) begin
            bus.req_d = 1; bus.addr_d = 16'(16'h2000 + i); bus.last_d = (i == 3);
            cycle();
            chk("C burst gnt", last_gnt, 3'b100);
        end
        bus.req_d = 0; bus.last_d = 0;
        cycle();
        chk("C gnt_e after burst", last_gnt, 3'b010);
        flush(3);

        // DMA without last_d: forced release after MAXB beats.
        bus.req_e = 1; bus.addr_e = 16'h0400;
        cnt = 0;
        for (int i = 0; i < MAXB; i++) begin
            bus.req_d = 1; bus.addr_d = 16'(i); bus.last_d = 0;
            cycle();
            if (last_gnt == 3'b100) cnt++;
        end
        chk("D beats", cnt, MAXB);
        chk("D released", bus.dma_active, 0);
        bus.req_d = 0;
        cycle();
        chk("D gnt_e", last_gnt, 3'b010);
        flush(3);

        // Executor RMW lock holds off DMA, including across an idle cycle.
        bus.req_e = 1; bus.we_e = 0; bus.addr_e = 16'h0010; bus.lock_e = 1;
        cycle();
        chk("E rmw read", last_gnt, 3'b010);
        bus.req_e = 0; bus.req_d = 1; bus.addr_d = 16'h3000; bus.last_d = 1;
        cycle();
        chk("E idle lock", last_gnt, 3'b000);
        bus.req_e = 1; bus.we_e = 1; bus.wdata_e = 8'h77; bus.lock_e = 0;
        cycle();
        chk("E rmw write", last_gnt, 3'b010);
        bus.req_e = 0;
        cycle();
        chk("E gnt_d after", last_gnt, 3'b100);
        flush(3);

        // Fetch starvation pattern under constant E pressure.
        bus.req_f = 1; bus.addr_f = 16'h8100;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            bus.req_e = 1; bus.we_e = 0; bus.lock_e = 0; bus.addr_e = 16'(16'h0500 + i);
            cycle();
            pat[i] = last_gnt[0];
        end
`ifdef ARB_STARVE_GUARD_EN
        pat_exp = 10'b10_0001_0000;
`else
        pat_exp = 10'b00_0000_0000;
`endif
        chk("F starve pattern", pat, pat_exp);
        flush(3);

        // Constrained-random traffic respecting the hold-until-granted handshake.
        pf = 0; pe = 0; pd = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!pf) begin
                pf = ($urandom_range(0, 2) != 0);
                bus.addr_f = 16'($urandom);
            end
            if (!pe) begin
                pe = ($urandom_range(0, 1) != 0);
                bus.addr_e = 16'($urandom); bus.we_e = 1'($urandom_range(0, 1));
                bus.wdata_e = 8'($urandom); bus.lock_e = ($urandom_range(0, 3) == 0);
            end
            if (!pd) begin
                pd = ($urandom_range(0, 3) == 0);
                bus.addr_d = 16'($urandom); bus.we_d = 1'($urandom_range(0, 1));
                bus.wdata_d = 8'($urandom); bus.last_d = ($urandom_range(0, 3) == 0);
            end
            bus.req_f = pf; bus.req_e = pe; bus.req_d = pd;
            bus.mem_rdata = 8'($urandom);
            cycle();
            if (m_g[0]) pf = 0;
            if (m_g[1]) pe = 0;
            if (m_g[2]) pd = 0;
        end
        flush(4);

        // Reset asserted inside a DMA lock with a read in flight.
        bus.req_d = 1; bus.we_d = 0; bus.addr_d = 16'h5000; bus.last_d = 0;
        cycle();
        chk("G in lock", bus.dma_active, 1);
        rst = 1;
        #1;
        chk_all_zero("G reset");
        model_reset();
        @(posedge clk); #1;
        chk("G squashed rvalid", {bus.rvalid_d, bus.rvalid_e, bus.rvalid_f}, 0);
        rst = 0;
        clear_inputs();
        bus.req_f = 1; bus.addr_f = 16'h8200;
        cycle();
        chk("G gnt_f after reset", last_gnt, 3'b001);
        flush(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
